fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage pipelined RV32I core. It owns the fetch PC, issues requests on a ready-based instruction-memory port, and applies stall and branch/jump redirect control. It drives InstrF/PCF/PC_Plus4F into the F/D pipeline register. It absorbs variable memory latency: it holds an instruction returned under stall, and it drains any in-flight request that a redirect has made stale.

## Interface
- RESET_PC, 32'h1000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0033, instruction driven when no valid fetch (ADD x0,x0,x0)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- StallF  in  1  hazard-unit stall; F/D register is not enabled while high
- PCSrcE  in  1  redirect request from EX (taken branch/jump)
- PCTargetE  in  32  redirect target; bits [1:0] ignored (forced 0)
- IMemReq  out  1  request valid
- IMemAddr  out  32  request address, word aligned
- IMemReady  in  1  response this cycle; completes the current request
- IMemRData  in  32  instruction data, valid when IMemReq & IMemReady
- InstrF  out  32  fetched instruction, or NOP_INSTR
- PCF  out  32  PC of InstrF
- PC_Plus4F  out  32  PCF + 4, modulo 2^32
- FetchValidF  out  1  InstrF is a real instruction
- FetchWaitF  out  1  stage is waiting on memory; hazard unit ORs this into the F/D stall

## Operation
- Registers: pc_q (32), redirect_q (32), hold_q (32), state ∈ {FETCH, HOLD, DROP}.
- Reset (rst high at a clock edge):
  - pc_q=RESET_PC, redirect_q=RESET_PC, hold_q=NOP_INSTR, state=FETCH.
  - While rst is high: IMemReq=0, FetchValidF=0, FetchWaitF=0, InstrF=NOP_INSTR, PCF=pc_q.
  - rst mid-request abandons the request. Memory is reset together with this block.
- FETCH:
  - IMemReq=1, IMemAddr=pc_q.
  - Priority 1, PCSrcE & IMemReady: data discarded, pc_q←target, stay FETCH.
  - Priority 1, PCSrcE & !IMemReady: redirect_q←target, go DROP.
  - Priority 2, IMemReady & !StallF: FetchValidF=1, InstrF=IMemRData, pc_q←pc_q+4.
  - Priority 2, IMemReady & StallF: hold_q←IMemRData, go HOLD. FetchValidF=1 this cycle, but F/D does not capture.
  - Priority 3, !IMemReady: FetchValidF=0, FetchWaitF=1, InstrF=NOP_INSTR.
- HOLD:
  - IMemReq=0, InstrF=hold_q, FetchValidF=1.
  - PCSrcE: pc_q←target, go FETCH. The held instruction is dropped.
  - !StallF: pc_q←pc_q+4, go FETCH.
  - Otherwise stay in HOLD.
- DROP:
  - IMemReq=1, IMemAddr=pc_q (the stale address, held stable until ready). FetchValidF=0, FetchWaitF=1, InstrF=NOP_INSTR.
  - PCSrcE again: redirect_q←newest target.
  - IMemReady: data discarded, pc_q←(PCSrcE ? target : redirect_q), go FETCH.
- In all states: PCF=pc_q, PC_Plus4F=pc_q+4.
- Arithmetic: 32-bit unsigned; 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- Port rule: IMemReq, once raised, stays high with a constant IMemAddr until IMemReady. The request is never withdrawn except by rst.

## Timing
- Zero-wait memory (IMemReady tied high): one instruction per cycle. PCF sequence RESET_PC, +4, +8, … starting the first cycle after rst falls.
- N-wait memory: InstrF valid in the cycle IMemReady=1. FetchWaitF is high for the N preceding cycles.
- Redirect with ready in the same cycle: the target is requested on the next cycle (1-cycle bubble).
- Redirect while waiting: the bubble lasts until the stale response arrives, plus 1 cycle.
- StallF has no effect on IMemReq in FETCH; a response is never lost.
- A redirect in the same cycle as a stall: redirect wins.
- All state changes happen on the rising edge. InstrF/FetchValidF are combinational from state, hold_q and IMemRData.

## Test plan
- Reset, zero-wait memory: after rst falls, IMemAddr = 0x1000_0000, 0x1000_0004, 0x1000_0008 on consecutive cycles. FetchValidF=1 each cycle. PC_Plus4F=PCF+4.
- 2-wait memory returning 0x0000_0513 for 0x1000_0000: FetchWaitF=1 for 2 cycles, then InstrF=0x0000_0513, PCF=0x1000_0000. The next request goes to 0x1000_0004.
- StallF held for 3 cycles across a response 0x00A0_0093: state HOLD, InstrF=0x00A0_0093 stable, IMemReq=0. After StallF falls, the request goes to PCF+4.
- PCSrcE with PCTargetE=0x1000_0042 while a 3-wait request to 0x1000_0008 is outstanding: IMemAddr stays 0x1000_0008 until ready, and its data never appears with FetchValidF=1. The next request goes to 0x1000_0040.
- pc_q=0xFFFF_FFFC with zero-wait memory: PC_Plus4F=0x0000_0000, and the next IMemAddr=0x0000_0000.
- rst asserted mid-wait: next cycle IMemReq=0, InstrF=0x0000_0033, PCF=0x1000_0000. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage pipelined RV32I core. Owns the fetch
//   PC and issues requests on a ready-based instruction-memory port. Applies
//   stall and branch/jump redirect control, and feeds InstrF/PCF/PC_Plus4F into
//   the F/D pipeline register. Handles variable memory latency: an instruction
//   returned under stall is parked in hold_q, and a request made stale by a
//   redirect is drained before the new target is requested.
//
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   StallF       hazard-unit stall (F/D register not enabled while high)
//   PCSrcE       redirect request from EX (taken branch/jump)
//   PCTargetE    redirect target, bits [1:0] ignored
//   IMemReq      request valid, held until IMemReady
//   IMemAddr     word-aligned request address
//   IMemReady    response this cycle, completes the current request
//   IMemRData    instruction data, valid when IMemReq & IMemReady
//   InstrF       fetched instruction or NOP_INSTR
//   PCF          PC of InstrF
//   PC_Plus4F    PCF + 4 (mod 2^32)
//   FetchValidF  InstrF is a real instruction
//   FetchWaitF   stage is waiting on memory
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PC_Plus4F,
  output logic        FetchValidF,
  output logic        FetchWaitF
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] redirect_q;
  logic [31:0] hold_q;

  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = PCTargetE & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;

  // ---------------------------------------------------------------------------
  // State and PC update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc_q       <= RESET_PC;
      redirect_q <= RESET_PC;
      hold_q     <= NOP_INSTR;
    end else begin
      case (state)
        FETCH: begin
          if (PCSrcE) begin
            if (IMemReady) begin
              // Response coincides with the redirect: discard it and
              // request the target next cycle.
              pc_q <= target;
            end else begin
              // The outstanding request cannot be withdrawn; remember the
              // target and drain the stale response first.
              redirect_q <= target;
              state      <= DROP;
            end
          end else if (IMemReady) begin
            if (!StallF) begin
              pc_q <= pc_plus4;
            end else begin
              hold_q <= IMemRData;
              state  <= HOLD;
            end
          end
        end

        HOLD: begin
          if (PCSrcE) begin
            pc_q  <= target;
            state <= FETCH;
          end else if (!StallF) begin
            pc_q  <= pc_plus4;
            state <= FETCH;
          end
        end

        DROP: begin
          if (IMemReady) begin
            // A redirect arriving with the stale response is the newest one.
            pc_q  <= PCSrcE ? target : redirect_q;
            state <= FETCH;
          end else if (PCSrcE) begin
            redirect_q <= target;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: combinational from state, hold_q and the memory response
  // ---------------------------------------------------------------------------
  always_comb begin
    IMemReq     = 1'b0;
    IMemAddr    = pc_q;
    InstrF      = NOP_INSTR;
    FetchValidF = 1'b0;
    FetchWaitF  = 1'b0;
    PCF         = pc_q;
    PC_Plus4F   = pc_plus4;

    if (!rst) begin
      case (state)
        FETCH: begin
          IMemReq = 1'b1;
          if (IMemReady) begin
            if (!PCSrcE) begin
              InstrF      = IMemRData;
              FetchValidF = 1'b1;
            end
          end else begin
            FetchWaitF = 1'b1;
          end
        end

        HOLD: begin
          InstrF      = hold_q;
          FetchValidF = 1'b1;
        end

        DROP: begin
          IMemReq    = 1'b1;
          FetchWaitF = 1'b1;
        end

        default: begin
          IMemReq = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRData;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PC_Plus4F;
  logic        FetchValidF;
  logic        FetchWaitF;

  fetch_stage #(
    .RESET_PC  (32'h1000_0000),
    .NOP_INSTR (32'h0000_0033)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemReady   (IMemReady),
    .IMemRData   (IMemRData),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PC_Plus4F   (PC_Plus4F),
    .FetchValidF (FetchValidF),
    .FetchWaitF  (FetchWaitF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t sb_q[$];

  int unsigned mem_wait = 0;
  int unsigned mem_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h1000_0000: mem_data = 32'h0000_0513;
      32'h1000_0004: mem_data = 32'h00A0_0093;
      default:       mem_data = {a[31:2], 2'b11};
    endcase
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    fetch_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  // One cycle: inputs applied 2 after the edge, memory responds at +3,
  // direct checks follow at +6 (monitor samples at the falling edge, +5).
  task automatic drive(input logic r, input logic s, input logic p, input logic [31:0] t);
    @(posedge clk);
    #2;
    rst       = r;
    StallF    = s;
    PCSrcE    = p;
    PCTargetE = t;
    #4;
  endtask

  // Memory responder with a programmable number of wait cycles
  initial begin
    IMemReady = 1'b0;
    IMemRData = 32'h0;
    forever begin
      @(posedge clk);
      #3;
      if (IMemReq) begin
        if (mem_cnt >= mem_wait) begin
          IMemReady = 1'b1;
          IMemRData = mem_data(IMemAddr);
          mem_cnt   = 0;
        end else begin
          IMemReady = 1'b0;
          IMemRData = 32'hDEAD_BEEF;
          mem_cnt++;
        end
      end else begin
        IMemReady = 1'b0;
        IMemRData = 32'hDEAD_BEEF;
        mem_cnt   = 0;
      end
    end
  end

  // Monitor: every instruction captured by F/D must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && FetchValidF && !StallF && !PCSrcE) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_capture actual pc=%h instr=%h expected none", PCF, InstrF);
      end else begin
        fetch_t e;
        e = sb_q.pop_front();
        chk("capture_pc", PCF, e.pc);
        chk("capture_instr", InstrF, e.instr);
        chk("capture_pc_plus4", PC_Plus4F, e.pc + 32'd4);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    StallF    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;

    // Reset state
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("rst_req", {31'b0, IMemReq}, 32'd0);
    chk("rst_valid", {31'b0, FetchValidF}, 32'd0);
    chk("rst_wait", {31'b0, FetchWaitF}, 32'd0);
    chk("rst_instr", InstrF, 32'h0000_0033);
    chk("rst_pcf", PCF, 32'h1000_0000);

    // Zero-wait streaming
    push(32'h1000_0000, 32'h0000_0513);
    push(32'h1000_0004, 32'h00A0_0093);
    push(32'h1000_0008, 32'h1000_000B);
    drive(0, 0, 0, 0);
    chk("zw_addr0", IMemAddr, 32'h1000_0000);
    chk("zw_valid0", {31'b0, FetchValidF}, 32'd1);
    drive(0, 0, 0, 0);
    chk("zw_addr1", IMemAddr, 32'h1000_0004);
    chk("zw_valid1", {31'b0, FetchValidF}, 32'd1);
    drive(0, 0, 0, 0);
    chk("zw_addr2", IMemAddr, 32'h1000_0008);
    chk("zw_plus4", PC_Plus4F, 32'h1000_000C);

    // 2-wait memory
    mem_wait = 2;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    push(32'h1000_0000, 32'h0000_0513);
    drive(0, 0, 0, 0);
    chk("w2_wait0", {31'b0, FetchWaitF}, 32'd1);
    chk("w2_valid0", {31'b0, FetchValidF}, 32'd0);
    chk("w2_nop0", InstrF, 32'h0000_0033);
    drive(0, 0, 0, 0);
    chk("w2_wait1", {31'b0, FetchWaitF}, 32'd1);
    drive(0, 0, 0, 0);
    chk("w2_wait2", {31'b0, FetchWaitF}, 32'd0);
    chk("w2_instr", InstrF, 32'h0000_0513);
    chk("w2_pcf", PCF, 32'h1000_0000);
    drive(0, 0, 0, 0);
    chk("w2_next_addr", IMemAddr, 32'h1000_0004);

    // Stall across a response: held in HOLD for 3 stalled cycles
    push(32'h1000_0004, 32'h00A0_0093);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk("st_resp_valid", {31'b0, FetchValidF}, 32'd1);
    chk("st_resp_instr", InstrF, 32'h00A0_0093);
    drive(0, 1, 0, 0);
    chk("hold_req", {31'b0, IMemReq}, 32'd0);
    chk("hold_instr", InstrF, 32'h00A0_0093);
    drive(0, 1, 0, 0);
    chk("hold_req2", {31'b0, IMemReq}, 32'd0);
    chk("hold_instr2", InstrF, 32'h00A0_0093);
    chk("hold_valid2", {31'b0, FetchValidF}, 32'd1);
    drive(0, 0, 0, 0);
    chk("hold_release_pcf", PCF, 32'h1000_0004);

    // Redirect while a 3-wait request to 0x1000_0008 is outstanding
    mem_wait = 3;
    drive(0, 0, 1, 32'h1000_0042);
    chk("rd_addr0", IMemAddr, 32'h1000_0008);
    chk("rd_valid0", {31'b0, FetchValidF}, 32'd0);
    drive(0, 0, 0, 0);
    chk("drop_addr1", IMemAddr, 32'h1000_0008);
    chk("drop_wait1", {31'b0, FetchWaitF}, 32'd1);
    drive(0, 0, 0, 0);
    chk("drop_addr2", IMemAddr, 32'h1000_0008);
    drive(0, 0, 0, 0);
    chk("drop_addr3", IMemAddr, 32'h1000_0008);
    chk("drop_valid3", {31'b0, FetchValidF}, 32'd0);
    chk("drop_instr3", InstrF, 32'h0000_0033);
    push(32'h1000_0040, 32'h1000_0043);
    drive(0, 0, 0, 0);
    chk("rd_target_addr", IMemAddr, 32'h1000_0040);
    chk("rd_target_req", {31'b0, IMemReq}, 32'd1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Redirect with ready in the same cycle, then address wrap
    mem_wait = 0;
    drive(0, 0, 1, 32'hFFFF_FFFE);
    chk("rdr_addr", IMemAddr, 32'h1000_0044);
    chk("rdr_valid", {31'b0, FetchValidF}, 32'd0);
    push(32'hFFFF_FFFC, 32'hFFFF_FFFF);
    push(32'h0000_0000, 32'h0000_0003);
    drive(0, 0, 0, 0);
    chk("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_Plus4F, 32'h0000_0000);
    drive(0, 0, 0, 0);
    chk("wrap_next_addr", IMemAddr, 32'h0000_0000);

    // Reset asserted mid-wait
    mem_wait = 3;
    drive(0, 0, 0, 0);
    chk("mw_wait", {31'b0, FetchWaitF}, 32'd1);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("mw_rst_req", {31'b0, IMemReq}, 32'd0);
    drive(1, 0, 0, 0);
    chk("mw_rst_req2", {31'b0, IMemReq}, 32'd0);
    chk("mw_rst_instr", InstrF, 32'h0000_0033);
    chk("mw_rst_pcf", PCF, 32'h1000_0000);
    mem_wait = 1;
    push(32'h1000_0000, 32'h0000_0513);
    drive(0, 0, 0, 0);
    chk("mw_restart_addr", IMemAddr, 32'h1000_0000);
    chk("mw_restart_req", {31'b0, IMemReq}, 32'd1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("mw_after_addr", IMemAddr, 32'h1000_0004);

    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
